nco_sweep_ctrl: RTL

- Frequency-sweep scheduler for the LUT-based NCO / IQ modulator.
- Drives the NCO's 8-bit frequency tuning word through a programmed stepped sweep: start word, signed step, step count, dwell time.
- Dwell is counted in NCO sample-enable ticks, so each tuning word is held for an exact number of output samples.
- Sits between the control/config logic and the NCO's freq_tuning_word input; consumes the NCO's enable_out.

---
 rtl/nco_pkg.sv | 33 +++
 rtl/nco_sweep_ctrl_if.sv | 30 +++
 rtl/nco_sweep_ctrl_dwell_counter.sv | 29 ++
 rtl/nco_sweep_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared constants and types for the NCO frequency-sweep scheduler.
package nco_pkg;

  localparam int unsigned FTW_W   = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DWELL_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DWELL,
    STEP,
    DONE
  } sweep_state_t;

  typedef struct packed {
    logic [FTW_W-1:0]   start_ftw;
    logic [FTW_W-1:0]   step_ftw;
    logic [CNT_W-1:0]   num_steps;
    logic [DWELL_W-1:0] dwell;
    logic               continuous;
  } sweep_cfg_t;

  // A programmed count of zero behaves as one.
  function automatic logic [DWELL_W-1:0] dwell_eff(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  function automatic logic [CNT_W-1:0] steps_eff(input logic [CNT_W-1:0] n);
    return (n == '0) ? CNT_W'(1) : n;
  endfunction

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Control/config and NCO-facing signals of the sweep scheduler.
interface nco_sweep_ctrl_if;
  import nco_pkg::*;

  logic               sample_en;
  logic               start;
  logic               abort;
  logic [FTW_W-1:0]   cfg_start_ftw;
  logic [FTW_W-1:0]   cfg_step_ftw;
  logic [CNT_W-1:0]   cfg_num_steps;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_continuous;
  logic [FTW_W-1:0]   freq_tuning_word;
  logic [CNT_W-1:0]   step_idx;
  logic               busy;
  logic               done;

  modport master (
    output sample_en, start, abort,
           cfg_start_ftw, cfg_step_ftw, cfg_num_steps, cfg_dwell, cfg_continuous,
    input  freq_tuning_word, step_idx, busy, done
  );

  modport slave (
    input  sample_en, start, abort,
           cfg_start_ftw, cfg_step_ftw, cfg_num_steps, cfg_dwell, cfg_continuous,
    output freq_tuning_word, step_idx, busy, done
  );

endinterface

// File: rtl/nco_sweep_ctrl_dwell_counter.sv
// Loadable down-counter of sample ticks; last flags the final tick of a dwell.
module dwell_counter
  import nco_pkg::*;
#(
  parameter int unsigned WIDTH = DWELL_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped frequency sweep of the NCO tuning word, dwelling a fixed number of sample ticks per word.
module nco_sweep_ctrl
  import nco_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  nco_sweep_ctrl_if.slave bus
);

  sweep_state_t     state, state_nxt;
  sweep_cfg_t       shadow;
  logic [FTW_W-1:0] ftw;
  logic [CNT_W-1:0] idx;
  logic             busy_q, done_q;

  logic capture, load_first, hop, dwell_load, dwell_tick, dwell_last, last_word;

  assign last_word = (idx >= (steps_eff(shadow.num_steps) - CNT_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    load_first = 1'b0;
    hop        = 1'b0;
    dwell_load = 1'b0;
    dwell_tick = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          capture   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_first = 1'b1;
        dwell_load = 1'b1;
        state_nxt  = DWELL;
      end
      DWELL: begin
        if (bus.sample_en) begin
          dwell_tick = 1'b1;
          if (dwell_last) state_nxt = STEP;
        end
      end
      STEP: begin
        if (!last_word) begin
          hop        = 1'b1;
          dwell_load = 1'b1;
          state_nxt  = DWELL;
        end else if (shadow.continuous) begin
          load_first = 1'b1;
          dwell_load = 1'b1;
          state_nxt  = DWELL;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every datapath update so the word and index freeze where they are.
    if (state != IDLE && bus.abort) begin
      state_nxt  = IDLE;
      load_first = 1'b0;
      hop        = 1'b0;
      dwell_load = 1'b0;
      dwell_tick = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
      ftw    <= '0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (capture) begin
        shadow <= '{start_ftw:  bus.cfg_start_ftw,
                    step_ftw:   bus.cfg_step_ftw,
                    num_steps:  bus.cfg_num_steps,
                    dwell:      bus.cfg_dwell,
                    continuous: bus.cfg_continuous};
      end
      if (load_first) begin
        ftw <= shadow.start_ftw;
        idx <= '0;
      end else if (hop) begin
        ftw <= ftw + shadow.step_ftw;
        idx <= idx + CNT_W'(1);
      end
      busy_q <= (state_nxt == LOAD) || (state_nxt == DWELL) || (state_nxt == STEP);
      done_q <= (state_nxt == DONE);
    end
  end

  dwell_counter #(.WIDTH(DWELL_W)) u_dwell (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (dwell_load),
    .load_val (dwell_eff(shadow.dwell)),
    .tick     (dwell_tick),
    .last     (dwell_last)
  );

  assign bus.freq_tuning_word = ftw;
  assign bus.step_idx         = idx;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule
